// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: programmable clock divider with clean start/stop sequencing,
// period-boundary ratio updates and a period counter. Optional burst mode: CLK_DIV_BURST_EN.
module clk_div_sequencer #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 15,
    parameter int TICK_WIDTH  = 32
) (
    input  logic                  IN_CLK,
    input  logic                  IN_RESETN,
    input  logic [CNT_WIDTH-1:0]  CFG_DIV,
    input  logic                  CFG_VALID,
    output logic                  CFG_READY,
    output logic                  CFG_ERR,
    input  logic                  START,
    input  logic                  STOP,
`ifdef CLK_DIV_BURST_EN
    input  logic [15:0]           CFG_BURST,
`endif
    output logic                  OUT_CLK,
    output logic                  OUT_CE,
    output logic                  BUSY,
    output logic [TICK_WIDTH-1:0] TICK_COUNT
);

    // state      | meaning
    // S_IDLE     | divider stopped, counter held at 0, outputs low
    // S_RUN      | generating periods continuously
    // S_STOPPING | finishing the current period, then back to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_DEFAULT_DIV = CNT_WIDTH'(DEFAULT_DIV);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_step;
    logic [CNT_WIDTH-1:0]   r_div;
    logic [CNT_WIDTH-1:0]   w_div_nxt;
    logic [CNT_WIDTH-1:0]   r_shadow;
    logic                   r_pending;
    logic                   r_err;
    logic                   r_out_clk;
    logic                   r_out_ce;
    logic [TICK_WIDTH-1:0]  r_tick;

    logic                   w_cfg_xfer;
    logic                   w_cfg_bad;
    logic                   w_last;
    logic                   w_wrap;
    logic                   w_apply;
    logic [CNT_WIDTH:0]     w_half_nxt;
    logic                   w_run_nxt;
    logic                   w_ce_nxt;
    logic                   w_clk_nxt;
    logic                   w_burst_done;

    // One extra bit keeps the compares correct at the maximum ratio.
    assign w_last     = {1'b0, r_cnt} == ({1'b0, r_div} - (CNT_WIDTH+1)'(1));
    assign w_wrap     = (r_state != S_IDLE) && w_last;
    assign w_cfg_xfer = CFG_VALID && !r_pending;
    assign w_cfg_bad  = CFG_DIV < CNT_WIDTH'(2);
    assign w_apply    = r_pending && ((r_state == S_IDLE) || w_wrap);
    assign w_div_nxt  = w_apply ? r_shadow : r_div;
    assign w_half_nxt = ({1'b0, w_div_nxt} + (CNT_WIDTH+1)'(1)) >> 1;

`ifdef CLK_DIV_BURST_EN
    logic [15:0] r_burst_len;
    logic [15:0] r_ce_cnt;

    assign w_burst_done = (r_burst_len != 16'd0) && (r_ce_cnt >= r_burst_len);

    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN) begin
            r_burst_len <= 16'd0;
            r_ce_cnt    <= 16'd0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_RUN)) begin
            r_burst_len <= CFG_BURST;
            r_ce_cnt    <= 16'd1;
        end else if (w_ce_nxt && (r_ce_cnt != 16'hFFFF)) begin
            r_ce_cnt    <= r_ce_cnt + 16'd1;
        end
    end
`else
    assign w_burst_done = 1'b0;
`endif

    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_step  = w_last ? '0 : r_cnt + CNT_WIDTH'(1);
        case (r_state)
            S_IDLE: begin
                if (START && !STOP) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (STOP || w_burst_done) w_state_nxt = S_STOPPING;
            end
            S_STOPPING: begin
                // A resume keeps the running phase; only a completed period drops to idle.
                if (START && !STOP && !w_burst_done) w_state_nxt = S_RUN;
                else if (w_last)                     w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_cnt_nxt = ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) ? '0 : w_cnt_step;
    end

    assign w_run_nxt = (w_state_nxt != S_IDLE);
    assign w_ce_nxt  = w_run_nxt && (w_cnt_nxt == '0);
    assign w_clk_nxt = w_run_nxt && ({1'b0, w_cnt_nxt} < w_half_nxt);

    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN) begin
            r_out_clk <= 1'b0;
            r_out_ce  <= 1'b0;
            r_tick    <= '0;
        end else begin
            r_out_clk <= w_clk_nxt;
            r_out_ce  <= w_ce_nxt;
            if (w_ce_nxt) r_tick <= r_tick + TICK_WIDTH'(1);
        end
    end

    // A transfer cannot coincide with an apply, since transfers need pending low.
    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN) begin
            r_div     <= C_DEFAULT_DIV;
            r_shadow  <= C_DEFAULT_DIV;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_cfg_xfer && w_cfg_bad;
            if (w_apply) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_cfg_xfer && !w_cfg_bad) begin
                r_shadow  <= CFG_DIV;
                r_pending <= 1'b1;
            end
        end
    end

    assign CFG_READY  = !r_pending;
    assign CFG_ERR    = r_err;
    assign OUT_CLK    = r_out_clk;
    assign OUT_CE     = r_out_ce;
    assign BUSY       = (r_state != S_IDLE);
    assign TICK_COUNT = r_tick;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer: vector table for idle config/start/stop,
// plus hand-written multi-cycle sequences for ratio change, stop, reset and burst.
module tb_clk_div_sequencer;

    logic        IN_CLK = 1'b0;
    logic        IN_RESETN;
    logic [15:0] CFG_DIV;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic        CFG_ERR;
    logic        START;
    logic        STOP;
    logic        OUT_CLK;
    logic        OUT_CE;
    logic        BUSY;
    logic [31:0] TICK_COUNT;
`ifdef CLK_DIV_BURST_EN
    logic [15:0] CFG_BURST;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 IN_CLK = ~IN_CLK;

    clk_div_sequencer #(.CNT_WIDTH(16), .DEFAULT_DIV(15), .TICK_WIDTH(32)) dut (
        .IN_CLK     (IN_CLK),
        .IN_RESETN  (IN_RESETN),
        .CFG_DIV    (CFG_DIV),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_ERR    (CFG_ERR),
        .START      (START),
        .STOP       (STOP),
`ifdef CLK_DIV_BURST_EN
        .CFG_BURST  (CFG_BURST),
`endif
        .OUT_CLK    (OUT_CLK),
        .OUT_CE     (OUT_CE),
        .BUSY       (BUSY),
        .TICK_COUNT (TICK_COUNT)
    );

    // in = {start, stop, valid}; e = {clk, ce, busy, ready, err} seen after the edge
    typedef struct {
        logic [2:0]  in;
        logic [15:0] div;
        logic [4:0]  e;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [2:0] in, logic [15:0] div, logic [4:0] e);
        vec_t v;
        v.in  = in;
        v.div = div;
        v.e   = e;
        return v;
    endfunction

    task automatic chk1(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge IN_CLK);
        #1;
    endtask

    task automatic apply_reset();
        IN_RESETN = 1'b0;
        START     = 1'b0;
        STOP      = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DIV   = 16'd0;
        step();
        step();
        IN_RESETN = 1'b1;
        step();
    endtask

    task automatic chk_reset_vals(string tag);
        chk1({tag, " clk"},   OUT_CLK,   1'b0);
        chk1({tag, " ce"},    OUT_CE,    1'b0);
        chk1({tag, " busy"},  BUSY,      1'b0);
        chk1({tag, " ready"}, CFG_READY, 1'b1);
        chk1({tag, " err"},   CFG_ERR,   1'b0);
        chkw({tag, " tick"},  TICK_COUNT, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ce;
`ifdef CLK_DIV_BURST_EN
        CFG_BURST = 16'd0;
`endif
        IN_RESETN = 1'b0;
        START     = 1'b0;
        STOP      = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DIV   = 16'd0;
        step();
        chk_reset_vals("reset");
        IN_RESETN = 1'b1;
        step();

        // Idle config errors, idle ratio load of 4, start, one period, stop.
        vecs[0]  = mk(3'b001, 16'd1, 5'b00011);
        vecs[1]  = mk(3'b000, 16'd0, 5'b00010);
        vecs[2]  = mk(3'b001, 16'd0, 5'b00011);
        vecs[3]  = mk(3'b000, 16'd0, 5'b00010);
        vecs[4]  = mk(3'b001, 16'd4, 5'b00000);
        vecs[5]  = mk(3'b000, 16'd0, 5'b00010);
        vecs[6]  = mk(3'b100, 16'd0, 5'b11110);
        vecs[7]  = mk(3'b000, 16'd0, 5'b10110);
        vecs[8]  = mk(3'b000, 16'd0, 5'b00110);
        vecs[9]  = mk(3'b000, 16'd0, 5'b00110);
        vecs[10] = mk(3'b000, 16'd0, 5'b11110);
        vecs[11] = mk(3'b010, 16'd0, 5'b10110);
        vecs[12] = mk(3'b000, 16'd0, 5'b00110);
        vecs[13] = mk(3'b000, 16'd0, 5'b00110);
        vecs[14] = mk(3'b000, 16'd0, 5'b00010);
        vecs[15] = mk(3'b000, 16'd0, 5'b00010);

        for (int i = 0; i < 16; i++) begin
            START     = vecs[i].in[2];
            STOP      = vecs[i].in[1];
            CFG_VALID = vecs[i].in[0];
            CFG_DIV   = vecs[i].div;
            step();
            START     = 1'b0;
            STOP      = 1'b0;
            CFG_VALID = 1'b0;
            chk1($sformatf("vec%0d clk", i),   OUT_CLK,   vecs[i].e[4]);
            chk1($sformatf("vec%0d ce", i),    OUT_CE,    vecs[i].e[3]);
            chk1($sformatf("vec%0d busy", i),  BUSY,      vecs[i].e[2]);
            chk1($sformatf("vec%0d ready", i), CFG_READY, vecs[i].e[1]);
            chk1($sformatf("vec%0d err", i),   CFG_ERR,   vecs[i].e[0]);
        end
        chkw("vec tick", TICK_COUNT, 32'd2);

        // Default ratio 15, then a mid-period change to 4.
        apply_reset();
        START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 60; k++) begin
            chk1($sformatf("d15 clk k%0d", k), OUT_CLK, (k % 15) < 8);
            chk1($sformatf("d15 ce k%0d", k),  OUT_CE,  (k % 15) == 0);
            if (k == 44) chkw("d15 tick", TICK_COUNT, 32'd3);
            if (k == 50) chk1("d15 ready before", CFG_READY, 1'b1);
            if (k >= 51) chk1($sformatf("d15 ready pend k%0d", k), CFG_READY, 1'b0);
            if (k == 50) begin
                CFG_VALID = 1'b1;
                CFG_DIV   = 16'd4;
            end
            step();
            CFG_VALID = 1'b0;
        end

        // Ratio 4 running; rejected writes leave the period untouched.
        for (int j = 0; j < 24; j++) begin
            chk1($sformatf("d4 clk j%0d", j),   OUT_CLK,   (j % 4) < 2);
            chk1($sformatf("d4 ce j%0d", j),    OUT_CE,    (j % 4) == 0);
            chk1($sformatf("d4 ready j%0d", j), CFG_READY, 1'b1);
            chk1($sformatf("d4 err j%0d", j),   CFG_ERR,   (j == 12) || (j == 14));
            if (j == 11) begin CFG_VALID = 1'b1; CFG_DIV = 16'd1; end
            if (j == 13) begin CFG_VALID = 1'b1; CFG_DIV = 16'd0; end
            if (j == 23) begin CFG_VALID = 1'b1; CFG_DIV = 16'd10; end
            step();
            CFG_VALID = 1'b0;
        end

        // Write accepted on a wrap edge: one more full ratio-4 period first.
        for (int j = 24; j < 28; j++) begin
            chk1($sformatf("wrapw clk j%0d", j),   OUT_CLK,   (j % 4) < 2);
            chk1($sformatf("wrapw ce j%0d", j),    OUT_CE,    (j % 4) == 0);
            chk1($sformatf("wrapw ready j%0d", j), CFG_READY, 1'b0);
            step();
        end

        // Ratio 10: STOP at counter 3 -> six more busy cycles, then idle.
        for (int m = 0; m < 4; m++) begin
            chk1($sformatf("d10 clk m%0d", m),   OUT_CLK,   m < 5);
            chk1($sformatf("d10 ce m%0d", m),    OUT_CE,    m == 0);
            chk1($sformatf("d10 ready m%0d", m), CFG_READY, 1'b1);
            if (m == 3) STOP = 1'b1;
            step();
            STOP = 1'b0;
        end
        for (int m = 4; m < 10; m++) begin
            chk1($sformatf("stop busy m%0d", m), BUSY,    1'b1);
            chk1($sformatf("stop clk m%0d", m),  OUT_CLK, m < 5);
            chk1($sformatf("stop ce m%0d", m),   OUT_CE,  1'b0);
            step();
        end
        chk1("stop idle busy", BUSY,    1'b0);
        chk1("stop idle clk",  OUT_CLK, 1'b0);
        chk1("stop idle ce",   OUT_CE,  1'b0);
        chkw("stop tick",      TICK_COUNT, 32'd12);
        step();
        chk1("stop after ce",   OUT_CE, 1'b0);
        chk1("stop after busy", BUSY,   1'b0);

        // START and STOP together while running: STOP wins.
        START = 1'b1;
        step();
        START = 1'b0;
        chk1("ss start ce",   OUT_CE, 1'b1);
        chk1("ss start busy", BUSY,   1'b1);
        step();
        START = 1'b1;
        STOP  = 1'b1;
        step();
        START = 1'b0;
        STOP  = 1'b0;
        for (int m = 2; m < 10; m++) begin
            chk1($sformatf("ss busy m%0d", m), BUSY, 1'b1);
            step();
        end
        chk1("ss idle busy", BUSY, 1'b0);
        chkw("ss tick",      TICK_COUNT, 32'd13);

        // Reset mid-period at ratio 7 with a pending config.
        apply_reset();
        CFG_VALID = 1'b1;
        CFG_DIV   = 16'd7;
        step();
        CFG_VALID = 1'b0;
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        CFG_VALID = 1'b1;
        CFG_DIV   = 16'd3;
        step();
        CFG_VALID = 1'b0;
        chk1("pre-rst clk",   OUT_CLK,   1'b1);
        chk1("pre-rst ready", CFG_READY, 1'b0);
        chk1("pre-rst busy",  BUSY,      1'b1);
        #2;
        IN_RESETN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        IN_RESETN = 1'b1;
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk1($sformatf("revert clk k%0d", k), OUT_CLK, (k % 15) < 8);
            chk1($sformatf("revert ce k%0d", k),  OUT_CE,  (k % 15) == 0);
            step();
        end

`ifdef CLK_DIV_BURST_EN
        // Burst of 3 periods at ratio 5.
        apply_reset();
        CFG_VALID = 1'b1;
        CFG_DIV   = 16'd5;
        step();
        CFG_VALID = 1'b0;
        step();
        CFG_BURST = 16'd3;
        START = 1'b1;
        step();
        START = 1'b0;
        n_ce = 0;
        for (int k = 0; k < 20; k++) begin
            if (OUT_CE) n_ce++;
            if (k == 14) chk1("burst busy k14", BUSY, 1'b1);
            if (k == 15) chk1("burst busy k15", BUSY, 1'b0);
            step();
        end
        chkw("burst ce count", n_ce, 32'd3);
        chkw("burst tick",     TICK_COUNT, 32'd3);
`else
        n_ce = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
